// File: rtl/byte_serializer_pkg.sv
// Shared types and constants for the byte serializer: frame FSM states and
// frame geometry.
package byte_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam int unsigned FRAME_BITS = 10;
  localparam int unsigned DATA_BITS  = 8;
  localparam int unsigned IDX_W      = 3;

endpackage

// File: rtl/bit_timer.sv
// Bit-period counter: while run is high, it counts 0..CLKS_PER_BIT-1 and
// raises bit_done_c during the last cycle of every period.
module bit_timer #(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic run,
  output logic bit_done_c
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic [CNT_W-1:0] cnt;

  // Held at zero while idle so that every frame starts on a fresh period.
  always_ff @(posedge clk) begin
    if (reset || !run) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign bit_done_c = run && (cnt == LAST);

endmodule

// File: rtl/byte_serializer.sv
// Byte-to-serial transmitter: accepts one byte in IDLE and sends a frame
// made of a start bit (0), eight data bits sent LSB first, and a stop bit (1).
module byte_serializer
  import byte_serializer_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter logic [7:0]  RESET_VALUE  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] d,
  input  logic       valid,
  output logic       ready,
  output logic [7:0] q,
  output logic       tx,
  output logic       busy
);

  state_t           state;
  state_t           state_nxt;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] idx_nxt;
  logic [7:0]       q_nxt;
  logic             tx_nxt;
  logic             bit_done_c;
  logic             accept_c;

  assign accept_c = valid && (state == IDLE);

  bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_timer (
    .clk       (clk),
    .reset     (reset),
    .run       (state != IDLE),
    .bit_done_c(bit_done_c)
  );

  // State and datapath registers; ready/busy are registered from the next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      q     <= RESET_VALUE;
      tx    <= 1'b1;
      idx   <= '0;
      ready <= 1'b1;
      busy  <= 1'b0;
    end else begin
      state <= state_nxt;
      q     <= q_nxt;
      tx    <= tx_nxt;
      idx   <= idx_nxt;
      ready <= (state_nxt == IDLE);
      busy  <= (state_nxt != IDLE);
    end
  end

  // Frame sequencing.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept_c) state_nxt = START;
      START:   if (bit_done_c) state_nxt = DATA;
      DATA:    if (bit_done_c && (idx == IDX_W'(DATA_BITS - 1))) state_nxt = STOP;
      STOP:    if (bit_done_c) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next line level, bit index and holding register.
  always_comb begin
    q_nxt   = q;
    tx_nxt  = tx;
    idx_nxt = idx;
    case (state)
      IDLE: begin
        tx_nxt  = 1'b1;
        idx_nxt = '0;
        if (accept_c) begin
          q_nxt  = d;
          tx_nxt = 1'b0;
        end
      end
      START: begin
        if (bit_done_c) begin
          tx_nxt  = q[0];
          idx_nxt = '0;
        end
      end
      DATA: begin
        if (bit_done_c) begin
          idx_nxt = idx + IDX_W'(1);
          tx_nxt  = (idx == IDX_W'(DATA_BITS - 1)) ? 1'b1 : q[idx_nxt];
        end
      end
      default: tx_nxt = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_byte_serializer.sv
// Bench for byte_serializer at CLKS_PER_BIT=4 and =1: directed scenarios plus
// random bytes, with the expected tx waveform built from the frame format.
module tb_byte_serializer;
  import byte_serializer_pkg::*;

  logic       clk;
  logic       reset;
  logic [7:0] d_a, d_b, q_a, q_b;
  logic       valid_a, valid_b, ready_a, ready_b, tx_a, tx_b, busy_a, busy_b;

  int checks = 0;
  int passed = 0;

  byte_serializer #(.CLKS_PER_BIT(4), .RESET_VALUE(8'h00)) dut_a (
    .clk(clk), .reset(reset), .d(d_a), .valid(valid_a),
    .ready(ready_a), .q(q_a), .tx(tx_a), .busy(busy_a)
  );

  byte_serializer #(.CLKS_PER_BIT(1), .RESET_VALUE(8'h00)) dut_b (
    .clk(clk), .reset(reset), .d(d_b), .valid(valid_b),
    .ready(ready_b), .q(q_b), .tx(tx_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic get_tx(input int w);
    return (w == 0) ? tx_a : tx_b;
  endfunction
  function automatic logic get_ready(input int w);
    return (w == 0) ? ready_a : ready_b;
  endfunction
  function automatic logic get_busy(input int w);
    return (w == 0) ? busy_a : busy_b;
  endfunction
  function automatic logic [7:0] get_q(input int w);
    return (w == 0) ? q_a : q_b;
  endfunction

  task automatic set_in(input int w, input logic v, input logic [7:0] dd);
    if (w == 0) begin
      valid_a = v;
      d_a     = dd;
    end else begin
      valid_b = v;
      d_b     = dd;
    end
  endtask

  // Reference: line level k cycles after acceptance.
  function automatic logic exp_bit(input logic [7:0] b, input int k, input int cpb);
    logic [FRAME_BITS-1:0] f;
    f = {1'b1, b, 1'b0};
    return f[k / cpb];
  endfunction

  task automatic idle_check(input int w, input logic [7:0] qexp, input string tag);
    chk({tag, "_tx"}, 8'(get_tx(w)), 8'd1);
    chk({tag, "_ready"}, 8'(get_ready(w)), 8'd1);
    chk({tag, "_busy"}, 8'(get_busy(w)), 8'd0);
    chk({tag, "_q"}, get_q(w), qexp);
  endtask

  // Starts at a negedge in IDLE; accepts b, checks the whole frame, ends at the
  // negedge of the idle cycle after the frame. keep_valid offers nxt during the
  // frame; poke (>=0) pulses valid with 8'hFF at that cycle offset.
  task automatic play_frame(input int w, input int cpb, input logic [7:0] b,
                            input logic keep_valid, input logic [7:0] nxt, input int poke);
    set_in(w, 1'b1, b);
    @(posedge clk);
    for (int k = 0; k < FRAME_BITS * cpb; k++) begin
      @(negedge clk);
      chk($sformatf("w%0d_b%02h_tx_k%0d", w, b, k), 8'(get_tx(w)), 8'(exp_bit(b, k, cpb)));
      chk($sformatf("w%0d_b%02h_busy_k%0d", w, b, k), 8'(get_busy(w)), 8'd1);
      chk($sformatf("w%0d_b%02h_ready_k%0d", w, b, k), 8'(get_ready(w)), 8'd0);
      chk($sformatf("w%0d_b%02h_q_k%0d", w, b, k), get_q(w), b);
      if (keep_valid) set_in(w, 1'b1, (k == FRAME_BITS * cpb - 1) ? nxt : 8'($urandom));
      else if (k == poke) set_in(w, 1'b1, 8'hFF);
      else set_in(w, 1'b0, 8'($urandom));
    end
    @(negedge clk);
    idle_check(w, b, $sformatf("w%0d_b%02h_after", w, b));
  endtask

  initial begin
    reset   = 1'b1;
    valid_a = 1'b0;
    valid_b = 1'b0;
    d_a     = 8'h00;
    d_b     = 8'h00;

    // Reset then idle.
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    idle_check(0, 8'h00, "idle_a");
    idle_check(1, 8'h00, "idle_b");

    // Reset together with valid wins.
    reset = 1'b1;
    set_in(0, 1'b1, 8'hAB);
    @(negedge clk);
    reset = 1'b0;
    idle_check(0, 8'h00, "rst_valid");
    set_in(0, 1'b0, 8'h00);
    @(negedge clk);

    // Single frame, then back-to-back frames with valid held high.
    play_frame(0, 4, 8'h98, 1'b0, 8'h00, -1);
    play_frame(0, 4, 8'h98, 1'b1, 8'h67, -1);
    play_frame(0, 4, 8'h67, 1'b0, 8'h00, -1);

    // valid pulse during DATA is ignored.
    play_frame(0, 4, 8'h98, 1'b0, 8'h00, 12);
    @(negedge clk);
    idle_check(0, 8'h98, "poke_idle");

    // Reset during data bit 3 aborts the frame.
    set_in(0, 1'b1, 8'h98);
    @(posedge clk);
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      chk($sformatf("pre_rst_tx_k%0d", k), 8'(tx_a), 8'(exp_bit(8'h98, k, 4)));
      set_in(0, 1'b0, 8'($urandom));
    end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    idle_check(0, 8'h00, "rst_mid");
    play_frame(0, 4, 8'h67, 1'b0, 8'h00, -1);

    // One cycle per bit.
    play_frame(1, 1, 8'h98, 1'b0, 8'h00, -1);
    play_frame(1, 1, 8'h98, 1'b1, 8'h67, -1);
    play_frame(1, 1, 8'h67, 1'b0, 8'h00, -1);

    // Random bytes with random idle gaps on both configurations.
    for (int w = 0; w < 2; w++) begin
      for (int n = 0; n < 5; n++) begin
        logic [7:0] b;
        int gap;
        b   = 8'($urandom);
        gap = int'($urandom_range(3, 0));
        play_frame(w, (w == 0) ? 4 : 1, b, 1'b0, 8'h00, -1);
        for (int g = 0; g < gap; g++) begin
          set_in(w, 1'b0, 8'($urandom));
          @(negedge clk);
          idle_check(w, b, $sformatf("gap_w%0d_n%0d", w, n));
        end
      end
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
